decode_memory_unit: RTL and testbench

- Byte-addressed unified instruction/data RAM for the single-cycle RV32I hart.
- Provides one synchronous write port with byte, half or word width, and one combinational 32-bit read port.
- The read word is decoded combinationally into RV32I instruction fields, so the hart can fetch and decode at `pc` in the same cycle.

---
 rtl/decode_memory_unit_pkg.sv | 47 ++++
 rtl/decode_memory_unit_instruction_decoder.sv | 34 +++
 rtl/decode_memory_unit.sv | 108 ++++++++++
 tb/tb_decode_memory_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/decode_memory_unit_pkg.sv
// Shared RV32I types, opcode/funct3 constants and small helpers used by the
// unified instruction/data RAM and its instruction field decoder.
package isa_types;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_IMM,
    OP_STORE,
    OP_UNKNOWN
  } opcode_t;

  typedef logic [4:0] rv_reg_t;

  typedef enum logic [1:0] {
    write_byte,
    write_half,
    write_word
  } write_width_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_ADDI = 3'd0;
  localparam logic [2:0] FUNCT3_LB   = 3'd0;
  localparam logic [2:0] FUNCT3_LH   = 3'd1;
  localparam logic [2:0] FUNCT3_LW   = 3'd2;
  localparam logic [2:0] FUNCT3_SB   = 3'd0;
  localparam logic [2:0] FUNCT3_SH   = 3'd1;
  localparam logic [2:0] FUNCT3_SW   = 3'd2;

  function automatic logic [XLEN-1:0] SIGEXT(input logic [11:0] value);
    return {{(XLEN-12){value[11]}}, value};
  endfunction

  function automatic logic [2:0] width_bytes(input write_width_t width);
    case (width)
      write_byte: return 3'd1;
      write_half: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/decode_memory_unit_instruction_decoder.sv
// Purely combinational RV32I field extractor; every field is driven from its
// fixed bit position whatever the opcode class turns out to be.
module instruction_decoder
  import isa_types::*;
(
  input  logic [ILEN-1:0] instr_bits,
  output opcode_t         opcode,
  output rv_reg_t         rs1,
  output rv_reg_t         rs2,
  output rv_reg_t         rd,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] s_imm
);

  always_comb begin
    case (instr_bits[6:0])
      OPC_LOAD:  opcode = OP_LOAD;
      OPC_IMM:   opcode = OP_IMM;
      OPC_STORE: opcode = OP_STORE;
      default:   opcode = OP_UNKNOWN;
    endcase
  end

  assign rs1    = instr_bits[19:15];
  assign rs2    = instr_bits[24:20];
  assign rd     = instr_bits[11:7];
  assign funct3 = instr_bits[14:12];
  assign funct7 = instr_bits[31:25];
  assign i_imm  = SIGEXT(instr_bits[31:20]);
  assign s_imm  = SIGEXT({instr_bits[31:25], instr_bits[11:7]});

endmodule

// File: rtl/decode_memory_unit.sv
// Byte-addressed unified RAM with a combinational fetch/decode read port.
// Optional macro DECODE_MEMORY_UNIT_RANGE_CHECK_EN replaces wrap with range checking.
module decode_memory_unit
  import isa_types::*;
#(
  parameter int DEPTH_BYTES = 256
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] waddr,
  input  logic [XLEN-1:0] raddr,
  input  write_width_t    wwidth,
  input  logic            wenable,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output opcode_t         opcode,
  output rv_reg_t         rs1,
  output rv_reg_t         rs2,
  output rv_reg_t         rd,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] s_imm
`ifdef DECODE_MEMORY_UNIT_RANGE_CHECK_EN
  ,
  output logic            addr_error
`endif
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]      mem_q [DEPTH_BYTES];
  logic [7:0]      mem_d [DEPTH_BYTES];
  logic [AW-1:0]   w_idx [4];
  logic [AW-1:0]   r_idx [4];
  logic [2:0]      wr_bytes;
  logic            wr_allowed;
  logic [XLEN-1:0] rdata_raw;

  // Each byte lane wraps on its own inside the AW-bit address space.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_idx[b] = waddr[AW-1:0] + AW'(b);
      r_idx[b] = raddr[AW-1:0] + AW'(b);
    end
  end

  assign wr_bytes  = width_bytes(wwidth);
  assign rdata_raw = {mem_q[r_idx[3]], mem_q[r_idx[2]], mem_q[r_idx[1]], mem_q[r_idx[0]]};

`ifdef DECODE_MEMORY_UNIT_RANGE_CHECK_EN
  logic [XLEN:0] r_end;
  logic [XLEN:0] w_end;
  logic          rd_err;
  logic          wr_err;

  assign r_end      = {1'b0, raddr} + (XLEN+1)'(3);
  assign w_end      = {1'b0, waddr} + (XLEN+1)'(wr_bytes) - (XLEN+1)'(1);
  assign rd_err     = (r_end >= (XLEN+1)'(DEPTH_BYTES));
  assign wr_err     = wenable && (w_end >= (XLEN+1)'(DEPTH_BYTES));
  assign addr_error = rd_err || wr_err;
  assign wr_allowed = wenable && !wr_err;
  assign rdata      = rd_err ? '0 : rdata_raw;
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^{waddr[XLEN-1:AW], raddr[XLEN-1:AW]};
  assign wr_allowed       = wenable;
  assign rdata            = rdata_raw;
`endif

  // Next-state image of the byte array: only the lanes covered by the width change.
  always_comb begin
    for (int i = 0; i < DEPTH_BYTES; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_allowed) begin
      for (int b = 0; b < 4; b++) begin
        if (3'(b) < wr_bytes) begin
          mem_d[w_idx[b]] = wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH_BYTES; i++) begin
      if (reset) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  instruction_decoder u_decoder (
    .instr_bits (rdata),
    .opcode     (opcode),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .funct3     (funct3),
    .funct7     (funct7),
    .i_imm      (i_imm),
    .s_imm      (s_imm)
  );

endmodule

// File: tb/tb_decode_memory_unit.sv
// Directed bench for decode_memory_unit (default build, modulo-wrap addressing).
// Table of write/read vectors plus hand sequences for read-during-write and reset.
module tb_decode_memory_unit;
  import isa_types::*;

  localparam int DEPTH = 256;

  logic            clock = 1'b0;
  logic            reset;
  logic [XLEN-1:0] waddr;
  logic [XLEN-1:0] raddr;
  write_width_t    wwidth;
  logic            wenable;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  opcode_t         opcode;
  rv_reg_t         rs1;
  rv_reg_t         rs2;
  rv_reg_t         rd;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;
`ifdef DECODE_MEMORY_UNIT_RANGE_CHECK_EN
  logic            addr_error;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         wen;
    write_width_t ww;
    logic [31:0]  waddr;
    logic [31:0]  wdata;
    logic [31:0]  raddr;
    logic [31:0]  exp_rdata;
    opcode_t      exp_op;
    logic [4:0]   exp_rd;
    logic [4:0]   exp_rs1;
    logic [4:0]   exp_rs2;
    logic [2:0]   exp_f3;
    logic [6:0]   exp_f7;
    logic [31:0]  exp_i;
    logic [31:0]  exp_s;
  } vec_t;

  vec_t vecs [11];

  decode_memory_unit #(.DEPTH_BYTES(DEPTH)) dut (
    .clock   (clock),
    .reset   (reset),
    .waddr   (waddr),
    .raddr   (raddr),
    .wwidth  (wwidth),
    .wenable (wenable),
    .wdata   (wdata),
    .rdata   (rdata),
    .opcode  (opcode),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .funct3  (funct3),
    .funct7  (funct7),
    .i_imm   (i_imm),
    .s_imm   (s_imm)
`ifdef DECODE_MEMORY_UNIT_RANGE_CHECK_EN
    ,
    .addr_error (addr_error)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clock);
    wenable = v.wen;
    wwidth  = v.ww;
    waddr   = v.waddr;
    wdata   = v.wdata;
    raddr   = v.raddr;
    @(posedge clock);
    #1;
    wenable = 1'b0;
  endtask

  task automatic check_vector(input int idx, input vec_t v);
    check_output($sformatf("v%0d.rdata", idx), rdata, v.exp_rdata);
    check_output($sformatf("v%0d.opcode", idx), 32'(opcode), 32'(v.exp_op));
    check_output($sformatf("v%0d.rd", idx), 32'(rd), 32'(v.exp_rd));
    check_output($sformatf("v%0d.rs1", idx), 32'(rs1), 32'(v.exp_rs1));
    check_output($sformatf("v%0d.rs2", idx), 32'(rs2), 32'(v.exp_rs2));
    check_output($sformatf("v%0d.funct3", idx), 32'(funct3), 32'(v.exp_f3));
    check_output($sformatf("v%0d.funct7", idx), 32'(funct7), 32'(v.exp_f7));
    check_output($sformatf("v%0d.i_imm", idx), i_imm, v.exp_i);
    check_output($sformatf("v%0d.s_imm", idx), s_imm, v.exp_s);
  endtask

  task automatic check_zero_read(input string tag, input logic [31:0] addr);
    @(negedge clock);
    raddr = addr;
    #1;
    check_output({tag, ".rdata"}, rdata, 32'h0);
    check_output({tag, ".opcode"}, 32'(opcode), 32'(OP_UNKNOWN));
    check_output({tag, ".i_imm"}, i_imm, 32'h0);
    check_output({tag, ".s_imm"}, s_imm, 32'h0);
  endtask

  initial begin
    //            wen   width       waddr  wdata         raddr  rdata         opcode      rd     rs1    rs2    f3    f7       i_imm         s_imm
    vecs[0]  = '{1'b1, write_byte, 32'd0,   32'h12345678, 32'd0,   32'h00000078, OP_UNKNOWN, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 32'h00000000};
    vecs[1]  = '{1'b1, write_half, 32'd2,   32'h0000AABB, 32'd0,   32'hAABB0078, OP_UNKNOWN, 5'd0,  5'd22, 5'd11, 3'd0, 7'h55, 32'hFFFFFAAB, 32'hFFFFFAA0};
    vecs[2]  = '{1'b1, write_word, 32'd0,   32'h00500793, 32'd0,   32'h00500793, OP_IMM,     5'd15, 5'd0,  5'd5,  3'd0, 7'h00, 32'h00000005, 32'h0000000F};
    vecs[3]  = '{1'b1, write_word, 32'd0,   32'hFFF78793, 32'd0,   32'hFFF78793, OP_IMM,     5'd15, 5'd15, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 32'hFFFFFFEF};
    vecs[4]  = '{1'b1, write_word, 32'd20,  32'h00E7A023, 32'd20,  32'h00E7A023, OP_STORE,   5'd0,  5'd15, 5'd14, 3'd2, 7'h00, 32'h0000000E, 32'h00000000};
    vecs[5]  = '{1'b1, write_word, 32'd20,  32'hFE7A2E23, 32'd20,  32'hFE7A2E23, OP_STORE,   5'd28, 5'd20, 5'd7,  3'd2, 7'h7F, 32'hFFFFFFE7, 32'hFFFFFFFC};
    vecs[6]  = '{1'b1, write_word, 32'd24,  32'h0007A703, 32'd24,  32'h0007A703, OP_LOAD,    5'd14, 5'd15, 5'd0,  3'd2, 7'h00, 32'h00000000, 32'h0000000E};
    vecs[7]  = '{1'b1, write_byte, 32'd28,  32'hFFFFFF5A, 32'd25,  32'h5A0007A7, OP_UNKNOWN, 5'd15, 5'd0,  5'd0,  3'd0, 7'h2D, 32'h000005A0, 32'h000005AF};
    vecs[8]  = '{1'b1, write_word, 32'd254, 32'hDEADBEEF, 32'd254, 32'hDEADBEEF, OP_UNKNOWN, 5'd29, 5'd27, 5'd10, 3'd3, 7'h6F, 32'hFFFFFDEA, 32'hFFFFFDFD};
    vecs[9]  = '{1'b0, write_word, 32'd0,   32'h12341234, 32'd0,   32'hFFF7DEAD, OP_UNKNOWN, 5'd29, 5'd15, 5'd31, 3'd5, 7'h7F, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[10] = '{1'b1, write_half, 32'h100, 32'h00000013, 32'd0,   32'hFFF70013, OP_IMM,     5'd0,  5'd14, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 32'hFFFFFFE0};

    reset   = 1'b1;
    wenable = 1'b0;
    wwidth  = write_byte;
    waddr   = '0;
    wdata   = '0;
    raddr   = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] reset state");
    check_zero_read("rst@0", 32'd0);
    check_zero_read("rst@4", 32'd4);
    check_zero_read("rst@252", 32'd252);

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i]);
      check_vector(i, vecs[i]);
    end

    $display("[TB] read during write, no bypass");
    @(negedge clock);
    raddr   = 32'd40;
    waddr   = 32'd40;
    wdata   = 32'hCAFEF00D;
    wwidth  = write_word;
    wenable = 1'b1;
    #1;
    check_output("rdw.before", rdata, 32'h0);
    @(posedge clock);
    #1;
    wenable = 1'b0;
    check_output("rdw.after", rdata, 32'hCAFEF00D);

    $display("[TB] reset overrides simultaneous write");
    @(negedge clock);
    reset   = 1'b1;
    wenable = 1'b1;
    wwidth  = write_word;
    waddr   = 32'd0;
    wdata   = 32'h11111111;
    raddr   = 32'd0;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    wenable = 1'b0;
    check_zero_read("rstw@0", 32'd0);
    check_zero_read("rstw@40", 32'd40);
    check_zero_read("rstw@254", 32'd254);
    check_zero_read("rstw@24", 32'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
